// File: rtl/apb_bram_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_bram_bridge_if
//
// Bundles the APB slave bus and the BRAM port-A signals that connect to
// apb_bram_bridge. The clock and reset are not part of the bundle.
//
// Signals:
//   psel, penable, pwrite   APB control from the master
//   paddr[31:0]             APB byte address
//   pwdata[31:0]            APB write data
//   pstrb[3:0]              APB byte strobes
//   prdata[31:0]            APB read data (zero above DATA_WIDTH)
//   pready, pslverr         APB completion and error
//   bram_addr               BRAM port-A word address
//   bram_we                 BRAM port-A write enable
//   bram_din                BRAM port-A write data
//   bram_dout               BRAM port-A read data (one-cycle registered read)
//
// Modports:
//   slave   the bridge side
//   master  the environment side (APB master plus the BRAM itself)
// -----------------------------------------------------------------------------
interface apb_bram_bridge_if #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           paddr;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic                  bram_we;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [DATA_WIDTH-1:0] bram_dout;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, bram_dout,
    output prdata, pready, pslverr, bram_addr, bram_we, bram_din
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, bram_dout,
    input  prdata, pready, pslverr, bram_addr, bram_we, bram_din
  );

endinterface

// File: rtl/apb_bram_bridge.sv
// -----------------------------------------------------------------------------
// apb_bram_bridge
//
// APB3/APB4 slave that turns APB transfers into word accesses on port A of the
// character/attribute BRAM. Port B belongs to the VGA scan-out and is not
// touched here.
//
//   - Full-strobe writes complete with zero wait states.
//   - Reads insert two wait states to cover the BRAM's registered read.
//   - Partial-strobe writes are done as read-modify-write, because the BRAM
//     has no byte enables; they also take two wait states.
//   - A write whose strobes cover none of the BRAM's byte lanes completes at
//     once without touching the BRAM.
//
// Ports:
//   clk_i  clock, shared with the BRAM
//   rst_i  asynchronous active-high reset
//   bus    apb_bram_bridge_if.slave: APB slave bus plus BRAM port A
//
// Parameters:
//   DATA_WIDTH  BRAM word width, 1..32
//   ADDR_WIDTH  BRAM word-address width (depth = 2**ADDR_WIDTH)
//   BASE_ADDR   APB byte address of BRAM word 0, 4-byte aligned
//
// Build option:
//   APB_BRAM_BRIDGE_SLVERR_EN  when defined, addresses below BASE_ADDR, beyond
//   the BRAM depth, or not word aligned complete immediately with pslverr=1
//   and no BRAM access. When undefined, pslverr is tied to 0, the word index
//   wraps to its low ADDR_WIDTH bits and paddr[1:0] is ignored.
// -----------------------------------------------------------------------------
module apb_bram_bridge #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  apb_bram_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    RMW_WAIT,
    RMW_MRG,
    RESP
  } state_t;

  // Byte lanes that actually exist in a BRAM word.
  localparam logic [3:0] LANE_MASK = {(DATA_WIDTH > 24), (DATA_WIDTH > 16),
                                      (DATA_WIDTH > 8), 1'b1};

  // Lane-wise merge for read-modify-write: strobed lanes take the new data,
  // the rest keep the word just read from the BRAM.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [3:0]            strb
  );
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      res[i] = strb[i/8] ? new_word[i] : old_word[i];
    end
    return res;
  endfunction

`ifdef APB_BRAM_BRIDGE_SLVERR_EN
  // Out-of-window or misaligned address. The offset check works on the
  // wrapped difference, so the explicit below-base test is still needed.
  function automatic logic addr_error(input logic [31:0] paddr);
    logic [31:0] off;
    off = paddr - BASE_ADDR;
    return (paddr < BASE_ADDR) ||
           ((off >> (ADDR_WIDTH + 2)) != 32'd0) ||
           (paddr[1:0] != 2'b00);
  endfunction
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic                  bram_we_q, bram_we_d;
  logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  pready_q, pready_d;
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
  logic                  pslverr_q, pslverr_d;
`endif

  // Transfer fields captured in the setup cycle for the RMW merge.
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            strb_q;

  logic                  setup;
  logic                  setup_err;
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]            lanes;
  logic                  unused_bits;

  assign setup    = bus.psel && !bus.penable;
  assign offset   = bus.paddr - BASE_ADDR;
  assign word_idx = offset[ADDR_WIDTH+1:2];
  assign lanes    = bus.pstrb & LANE_MASK;

`ifdef APB_BRAM_BRIDGE_SLVERR_EN
  assign setup_err = addr_error(bus.paddr);
`else
  assign setup_err = 1'b0;
`endif

  // Bits of the bus that a narrow or non-checking build never looks at.
  assign unused_bits = ^{bus.pwdata, bus.paddr, offset, strb_q};

  // Next-state and next-output logic. Pulse outputs default low so that every
  // path through RESP, an abort or reset leaves them single-cycle.
  always_comb begin
    state_d     = state_q;
    bram_addr_d = bram_addr_q;
    bram_we_d   = 1'b0;
    bram_din_d  = bram_din_q;
    prdata_d    = prdata_q;
    pready_d    = 1'b0;
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
    pslverr_d   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (setup) begin
          if (setup_err) begin
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
            pslverr_d = 1'b1;
`endif
            pready_d  = 1'b1;
            state_d   = RESP;
          end else begin
            bram_addr_d = word_idx;
            if (!bus.pwrite) begin
              state_d = RD_WAIT;
            end else if (lanes == 4'h0) begin
              pready_d = 1'b1;
              state_d  = RESP;
            end else if (lanes == LANE_MASK) begin
              bram_we_d  = 1'b1;
              bram_din_d = bus.pwdata[DATA_WIDTH-1:0];
              pready_d   = 1'b1;
              state_d    = RESP;
            end else begin
              state_d = RMW_WAIT;
            end
          end
        end
      end

      // --- BRAM address presented; read data arrives next cycle ---
      RD_WAIT: begin
        state_d = bus.psel ? RD_CAP : IDLE;
      end

      // --- BRAM read data valid: capture for the APB master ---
      RD_CAP: begin
        if (bus.psel) begin
          prdata_d = 32'(bus.bram_dout);
          pready_d = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = IDLE;
        end
      end

      RMW_WAIT: begin
        state_d = bus.psel ? RMW_MRG : IDLE;
      end

      // --- Old word valid: merge strobed lanes and write back ---
      RMW_MRG: begin
        if (bus.psel) begin
          bram_din_d = merge_lanes(bus.bram_dout, wdata_q, strb_q);
          bram_we_d  = 1'b1;
          pready_d   = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = IDLE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bram_addr_q <= '0;
      bram_we_q   <= 1'b0;
      bram_din_q  <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
      pslverr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bram_addr_q <= bram_addr_d;
      bram_we_q   <= bram_we_d;
      bram_din_q  <= bram_din_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
      pslverr_q   <= pslverr_d;
`endif
    end
  end

  // Write data and strobes are only consumed in RMW_MRG, which is always
  // preceded by a setup cycle, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && setup) begin
      wdata_q <= bus.pwdata[DATA_WIDTH-1:0];
      strb_q  <= bus.pstrb;
    end
  end

  assign bus.bram_addr = bram_addr_q;
  assign bus.bram_we   = bram_we_q;
  assign bus.bram_din  = bram_din_q;
  assign bus.prdata    = prdata_q;
  assign bus.pready    = pready_q;
`ifdef APB_BRAM_BRIDGE_SLVERR_EN
  assign bus.pslverr   = pslverr_q;
`else
  assign bus.pslverr   = 1'b0;
`endif

endmodule
